lsu_data_mem: RTL

Parametrised data memory with RISC-V load/store sizing for the CPU's MEM stage. It supports byte, halfword and word accesses selected by funct3, with sign or zero extension on loads and byte-lane masking on stores. Memory latency is configurable through a request/done handshake with programmable wait states, so the pipeline can stall on it. Misaligned, out-of-range and illegal-size accesses are flagged and never modify memory.

---
 rtl/riscv_defs.sv | 57 +++++
 rtl/dmem_bank.sv | 22 ++
 rtl/lsu_data_mem.sv | 133 +++++++++++++
 3 files changed

// File: rtl/riscv_defs.sv
// Shared RV32I load/store encodings, LSU fault codes and FSM states,
// plus the fault-check and load-extension helpers used by lsu_data_mem.
package riscv_defs;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_RANGE    = 2'd2,
    FAULT_ILLEGAL  = 2'd3
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // Priority: illegal size, then out of range, then misaligned.
  function automatic fault_e check_fault(input logic        is_store,
                                         input logic [2:0]  f3,
                                         input logic [31:0] a,
                                         input int unsigned depth);
    logic illegal;
    logic misalign;
    if (is_store) illegal = (f3 > F3_SW);
    else          illegal = !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    misalign = ((f3[1:0] == 2'd1) && a[0]) || ((f3[1:0] == 2'd2) && (a[1:0] != 2'd0));
    if (illegal)                          return FAULT_ILLEGAL;
    else if ({2'b00, a[31:2]} >= depth)   return FAULT_RANGE;
    else if (misalign)                    return FAULT_MISALIGN;
    return FAULT_NONE;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      F3_LB:   return {{24{sh[7]}}, sh[7:0]};
      F3_LH:   return {{16{sh[15]}}, sh[15:0]};
      F3_LBU:  return {24'd0, sh[7:0]};
      F3_LHU:  return {16'd0, sh[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// DEPTH x 32 data RAM with per-byte write enables and a registered read port.
module dmem_bank #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    o_rdata <= r_mem[i_idx];
  end

endmodule

// File: rtl/lsu_data_mem.sv
// MEM-stage data memory: RV32I sized loads/stores behind a busy/done handshake
// with programmable wait states and fault reporting.
//
//   state     | meaning
//   ST_IDLE   | ready; accepts a request and runs the fault check
//   ST_WAIT   | counting wait states down to terminal count
//   ST_ACCESS | next edge performs the write / registers the load, pulses done
module lsu_data_mem
  import riscv_defs::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] read_data,
  output logic [1:0]  fault
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e        r_state;
  logic [3:0]    r_cnt;
  logic          r_write;
  logic [2:0]    r_f3;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_lane;
  logic [31:0]   r_wdata;
  fault_e        r_fault;

  logic          w_req;
  fault_e        w_fault;
  logic [3:0]    w_mask;
  logic [3:0]    w_we;
  logic [31:0]   w_wdata;
  logic [31:0]   w_rdata;
  logic [AW-1:0] w_bank_idx;

  assign w_req   = MemRead | MemWrite;
  assign w_fault = check_fault(MemWrite, funct3, addr, DEPTH);

  always_comb begin
    w_mask  = 4'b1111;
    w_wdata = r_wdata;
    case (r_f3)
      F3_SB: begin
        w_mask  = 4'b0001 << r_lane;
        w_wdata = {4{r_wdata[7:0]}};
      end
      F3_SH: begin
        w_mask  = r_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // A reset landing on the ACCESS edge must not commit the store.
  assign w_we = (r_state == ST_ACCESS && r_write && r_fault == FAULT_NONE && !rst)
                ? w_mask : 4'b0000;

  // Read port follows the live address while idle so the registered read is
  // already holding the target word by the ACCESS edge, even with zero waits.
  assign w_bank_idx = (r_state == ST_IDLE) ? addr[AW+1:2] : r_idx;

  dmem_bank #(.DEPTH(DEPTH)) u_bank (
    .clk     (clk),
    .i_we    (w_we),
    .i_idx   (w_bank_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_write   <= 1'b0;
      r_f3      <= 3'd0;
      r_idx     <= '0;
      r_lane    <= 2'd0;
      r_wdata   <= 32'd0;
      r_fault   <= FAULT_NONE;
      busy      <= 1'b0;
      done      <= 1'b0;
      read_data <= 32'd0;
      fault     <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (w_req) begin
            r_write <= MemWrite;
            r_f3    <= funct3;
            r_idx   <= addr[AW+1:2];
            r_lane  <= addr[1:0];
            r_wdata <= write_data;
            r_fault <= w_fault;
            busy    <= 1'b1;
            if (WAIT_CYCLES > 0 && w_fault == FAULT_NONE) begin
              r_state <= ST_WAIT;
              r_cnt   <= WAIT_LOAD;
            end else begin
              r_state <= ST_ACCESS;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) r_state <= ST_ACCESS;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        ST_ACCESS: begin
          r_state   <= ST_IDLE;
          busy      <= 1'b0;
          done      <= 1'b1;
          fault     <= r_fault;
          read_data <= (r_write || r_fault != FAULT_NONE)
                       ? 32'd0 : load_extend(w_rdata, r_f3, r_lane);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
